// File: rtl/seq_shifter_if.sv
// Request/response bundle for the multi-cycle shifter.
// master = requester (controller / bench), slave = shifter.
interface seq_shifter_if #(
  parameter int W     = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [2:0]       op;
  logic [W-1:0]     in;
  logic [AMT_W-1:0] amt;
  logic             busy;
  logic             done;
  logic [W-1:0]     sout;

  modport master (
    output start, op, in, amt,
    input  busy, done, sout
  );

  modport slave (
    input  start, op, in, amt,
    output busy, done, sout
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: pass / LSL / LSR / ASR / ROL / ROR by a variable
// amount, up to STEP bit positions per clock, with start/busy/done handshake.
module seq_shifter #(
  parameter int W     = 16,
  parameter int AMT_W = 4,
  parameter int STEP  = 1
) (
  input  logic       clk,
  input  logic       reset,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  state_t           state_reg;
  state_t           state_next;
  logic [W-1:0]     work_reg;
  logic [2:0]       op_reg;
  logic [AMT_W-1:0] rem_reg;
  logic [W-1:0]     sout_reg;

  logic [W-1:0]     shifted;
  logic [AMT_W-1:0] rem_step;
  logic             start_direct;

  // One bit position of the selected operation. ASR replicates the current
  // MSB, which stays equal to the original sign across all steps.
  function automatic logic [W-1:0] step1(input logic [2:0] o, input logic [W-1:0] w);
    case (o)
      OP_LSL:  return {w[W-2:0], 1'b0};
      OP_LSR:  return {1'b0, w[W-1:1]};
      OP_ASR:  return {w[W-1], w[W-1:1]};
      OP_ROL:  return {w[W-2:0], w[W-1]};
      OP_ROR:  return {w[0], w[W-1:1]};
      default: return w;
    endcase
  endfunction

  // Requests that complete without any shift cycles: pass codes or amt=0.
  always_comb begin
    start_direct = (bus.op == 3'b000) || (bus.op[2:1] == 2'b11) || (bus.amt == '0);
  end

  // Per-cycle datapath: apply min(STEP, remaining) single-bit steps.
  always_comb begin
    shifted = work_reg;
    for (int i = 0; i < STEP; i++) begin
      if (int'(rem_reg) > i) begin
        shifted = step1(op_reg, shifted);
      end
    end
    if (int'(rem_reg) > STEP) begin
      rem_step = rem_reg - AMT_W'(STEP);
    end else begin
      rem_step = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = start_direct ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (rem_step == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iterative shifting and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_reg <= '0;
      op_reg   <= '0;
      rem_reg  <= '0;
      sout_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            work_reg <= bus.in;
            op_reg   <= bus.op;
            rem_reg  <= bus.amt;
            if (start_direct) begin
              sout_reg <= bus.in;
            end
          end
        end
        SHIFT: begin
          work_reg <= shifted;
          rem_reg  <= rem_step;
          if (rem_step == '0) begin
            sout_reg <= shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from the state register.
  always_comb begin
    bus.busy = (state_reg != IDLE);
    bus.done = (state_reg == DONE);
    bus.sout = sout_reg;
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: three builds (W16/STEP1, W16/STEP4, W8/STEP3) run
// the same requests in lockstep against an arithmetic reference model.
module tb_seq_shifter;

  logic clk = 1'b0;
  logic reset;

  logic        start_i [3];
  logic [2:0]  op_i    [3];
  logic [15:0] in_i    [3];
  logic [3:0]  amt_i   [3];

  int tests = 0;
  int fails = 0;

  seq_shifter_if #(.W(16), .AMT_W(4)) if0 ();
  seq_shifter_if #(.W(16), .AMT_W(4)) if1 ();
  seq_shifter_if #(.W(8),  .AMT_W(4)) if2 ();

  assign if0.start = start_i[0];
  assign if0.op    = op_i[0];
  assign if0.in    = in_i[0];
  assign if0.amt   = amt_i[0];
  assign if1.start = start_i[1];
  assign if1.op    = op_i[1];
  assign if1.in    = in_i[1];
  assign if1.amt   = amt_i[1];
  assign if2.start = start_i[2];
  assign if2.op    = op_i[2];
  assign if2.in    = in_i[2][7:0];
  assign if2.amt   = amt_i[2];

  seq_shifter #(.W(16), .AMT_W(4), .STEP(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  seq_shifter #(.W(16), .AMT_W(4), .STEP(4)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  seq_shifter #(.W(8),  .AMT_W(4), .STEP(3)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  always #5 clk = ~clk;

  function automatic int wd(input int d);
    return (d == 2) ? 8 : 16;
  endfunction

  function automatic int sd(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 3);
  endfunction

  function automatic logic [15:0] obs_busy(input int d);
    return (d == 0) ? 16'(if0.busy) : ((d == 1) ? 16'(if1.busy) : 16'(if2.busy));
  endfunction

  function automatic logic [15:0] obs_done(input int d);
    return (d == 0) ? 16'(if0.done) : ((d == 1) ? 16'(if1.done) : 16'(if2.done));
  endfunction

  function automatic logic [15:0] obs_sout(input int d);
    return (d == 0) ? if0.sout : ((d == 1) ? if1.sout : {8'h00, if2.sout});
  endfunction

  // Whole-operation result computed directly from shift/rotate arithmetic.
  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] val,
                                             input int amt, input int w);
    logic [31:0] mask, x, r;
    int rr;
    mask = (32'd1 << w) - 32'd1;
    x    = {16'h0000, val} & mask;
    rr   = amt % w;
    case (op)
      3'd1: r = x << amt;
      3'd2: r = x >> amt;
      3'd3: begin
        if (x[w-1]) x = x | ~mask;
        r = 32'($signed(x) >>> amt);
      end
      3'd4: r = (x << rr) | (x >> (w - rr));
      3'd5: r = (x >> rr) | (x << (w - rr));
      default: r = x;
    endcase
    r = r & mask;
    return r[15:0];
  endfunction

  function automatic int lat_of(input logic [2:0] op, input int amt, input int step);
    if (op == 3'd0 || op >= 3'd6 || amt == 0) return 0;
    return (amt + step - 1) / step;
  endfunction

  task automatic check(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, d, obs, exp);
    end
  endtask

  // Issues one request to all builds at the current negedge and follows each
  // through SHIFT/DONE back to IDLE; with noise, start/in/op/amt toggle
  // randomly while the unit is busy.
  task automatic run_op(input logic [2:0] op, input logic [15:0] val, input logic [3:0] amt,
                        input bit noise);
    int          lat [3];
    logic [15:0] exp [3];
    bit          fin [3];
    for (int d = 0; d < 3; d++) begin
      exp[d]     = ref_result(op, val, int'(amt), wd(d));
      lat[d]     = lat_of(op, int'(amt), sd(d));
      fin[d]     = 1'b0;
      start_i[d] = 1'b1;
      op_i[d]    = op;
      in_i[d]    = val;
      amt_i[d]   = amt;
    end
    $display("[TB] op=%0d in=%h amt=%0d noise=%0d exp=%h/%h/%h lat=%0d/%0d/%0d",
             op, val, amt, noise, exp[0], exp[1], exp[2], lat[0], lat[1], lat[2]);
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!fin[d]) begin
          if (n <= lat[d] + 1) begin
            check("busy", d, obs_busy(d), 16'd1);
            check("done", d, obs_done(d), 16'(n == lat[d] + 1));
            if (n == lat[d] + 1) check("sout", d, obs_sout(d), exp[d]);
            if (noise) begin
              start_i[d] = 1'($urandom);
              op_i[d]    = 3'($urandom);
              in_i[d]    = 16'($urandom);
              amt_i[d]   = 4'($urandom);
            end else begin
              start_i[d] = 1'b0;
            end
          end else begin
            check("idle_busy", d, obs_busy(d), 16'd0);
            check("idle_done", d, obs_done(d), 16'd0);
            check("hold_sout", d, obs_sout(d), exp[d]);
            start_i[d] = 1'b0;
            fin[d]     = 1'b1;
          end
        end
      end
      if (fin[0] && fin[1] && fin[2]) break;
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_i[d] = 1'b0;
      op_i[d]    = 3'd0;
      in_i[d]    = 16'h0000;
      amt_i[d]   = 4'd0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", d, obs_busy(d), 16'd0);
      check("rst_done", d, obs_done(d), 16'd0);
      check("rst_sout", d, obs_sout(d), 16'h0000);
    end
    reset = 1'b0;
    @(negedge clk);

    // Directed cases: pass, legacy amt=1, ASR, rotates, long LSR, saturation.
    run_op(3'd0, 16'h0005, 4'd9,  1'b0);
    run_op(3'd1, 16'h0002, 4'd1,  1'b0);
    run_op(3'd2, 16'h8001, 4'd1,  1'b0);
    run_op(3'd3, 16'hE000, 4'd1,  1'b0);
    run_op(3'd3, 16'h6000, 4'd1,  1'b0);
    run_op(3'd3, 16'hF0CF, 4'd1,  1'b0);
    run_op(3'd3, 16'hE000, 4'd3,  1'b0);
    run_op(3'd5, 16'hF0CF, 4'd4,  1'b0);
    run_op(3'd4, 16'h8001, 4'd1,  1'b0);
    run_op(3'd2, 16'h8000, 4'd15, 1'b0);
    run_op(3'd2, 16'hFFFF, 4'd15, 1'b0);
    run_op(3'd3, 16'h0080, 4'd12, 1'b0);
    run_op(3'd7, 16'h1234, 4'd5,  1'b0);
    run_op(3'd4, 16'hA5C3, 4'd0,  1'b0);
    // Requests hammered during SHIFT and DONE must be ignored.
    run_op(3'd1, 16'h0003, 4'd7,  1'b1);
    run_op(3'd4, 16'h9001, 4'd13, 1'b1);

    // Reset in the middle of a 10-position LSL: abandoned, no done pulse.
    $display("[TB] reset mid-shift: op=1 in=0001 amt=10");
    for (int d = 0; d < 3; d++) begin
      start_i[d] = 1'b1;
      op_i[d]    = 3'd1;
      in_i[d]    = 16'h0001;
      amt_i[d]   = 4'd10;
    end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) start_i[d] = 1'b0;
      if (n == 5) begin
        check("pre_rst_busy", 0, obs_busy(0), 16'd1);
        reset = 1'b1;
      end else if (n == 6) begin
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
          check("abort_busy", d, obs_busy(d), 16'd0);
          check("abort_done", d, obs_done(d), 16'd0);
          check("abort_sout", d, obs_sout(d), 16'h0000);
        end
      end else if (n > 6) begin
        check("no_done_after_abort", 0, obs_done(0), 16'd0);
      end
    end

    // Randomized requests.
    for (int t = 0; t < 60; t++) begin
      run_op(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
